joybus_uart_bridge: RTL and testbench
=====================================

// Module: joybus_uart_bridge
// PURPOSE
//  Multi-controller successor to the single-channel JOYBUS->UART path: accepts NUM_CH controller
//  status words (one per JOYBUS host), holds the latest sample per channel, arbitrates round-robin,
//  emits framed packets on one 8N1 UART TX line. Sits between the JOYBUS host array and the TX pin.
//  Adds change-only filtering, per-channel enable and overrun reporting.
// PARAMETERS
//  NUM_CH       4           number of controller channels, 1..16
//  DATA_W       32          bits per controller sample, multiple of 8
//  CLK_FREQ     50_000_000  clk frequency, Hz
//  BAUD         115200      UART bit rate; BAUD_DIV = round(CLK_FREQ/BAUD), must be >= 2
//  CHANGE_ONLY  1           1: a sample equal to the channel's last-sent word is dropped
// PORTS
//  clk             in   1             system clock, single domain
//  rst_n           in   1             synchronous, active-low reset
//  cntlr_data      in   NUM_CH*DATA_W channel c occupies [c*DATA_W +: DATA_W]
//  cntlr_data_rdy  in   NUM_CH        per-channel 1-cycle strobe: cntlr_data slice valid
//  ch_enable       in   NUM_CH        1 = channel accepted; 0 = strobes ignored, pending masked
//  overrun_clr     in   1             1-cycle pulse clears all overrun bits
//  overrun         out  NUM_CH        sticky: unsent sample overwritten on that channel
//  busy            out  1             high while a frame is in progress
//  TX              out  1             UART serial out, idle high
// BEHAVIOUR
//  Reset: TX=1, busy=0, overrun=0, all pending=0, last_sent=0, rr_ptr=0, FSM=IDLE, no partial frame
//   resumed; reset mid-frame forces TX=1 on the edge where rst_n is sampled low.
//  Capture, per channel c, on cntlr_data_rdy[c] & ch_enable[c]:
//   - CHANGE_ONLY=1 and slice == last_sent[c] -> ignored (hold and pending unchanged).
//   - else hold[c] <= slice, pending[c] <= 1; if pending[c] already 1 -> overrun[c] <= 1.
//   - strobe in the same cycle LOAD snapshots c: snapshot takes the OLD hold; new sample written,
//     pending stays 1; no overrun. overrun_clr coincident with new overrun: set wins.
//  Arbitration: in IDLE, eligible = pending & ch_enable. Winner = first eligible index searching
//   rr_ptr, rr_ptr+1, ... modulo NUM_CH. rr_ptr <= winner+1 (wraps NUM_CH-1 -> 0) at LOAD.
//  FSM: IDLE -(eligible!=0)-> LOAD (1 cycle: snapshot hold[w], pending[w]<=0, last_sent[w]<=hold[w],
//   ch<=w) -> HDR -> DATA x (DATA_W/8) -> CSUM -> IDLE. busy = (state != IDLE).
//  Frame bytes: HDR = 8'hA0 | ch; DATA MSB byte first; CSUM = XOR of HDR and all DATA bytes.
//  Byte hand-off: FSM raises tx_start with tx_byte while uart_tx tx_ready=1; accepted same cycle;
//   next byte offered when tx_ready returns. Back-to-back frames: no idle gap beyond 1 stop bit + LOAD.
//  UART: start bit 0, 8 data bits LSB first, 1 stop bit 1; each bit exactly BAUD_DIV clks;
//   tx_ready=1 in the cycle after the stop bit's last clk. First start bit drives TX 1 clk after accept.
//  Latency: strobe at cycle t on idle bridge -> LOAD at t+2 (pending set t+1) -> start bit at t+4.
//  ch_enable deassert while pending: pending retained, not arbitrated until re-enabled.
//   Deassert during own frame: frame completes.
// STRUCTURE
//  Package joybus_pkg: FRAME_HDR_BASE=8'hA0, state enum (IDLE,LOAD,HDR,DATA,CSUM),
//   function baud_div(CLK_FREQ,BAUD).
//  Sub-module uart_tx (BAUD_DIV param; clk, rst_n, tx_start, tx_byte[7:0], tx_ready, TX).
//  Top holds capture regs, round-robin arbiter, framing FSM, checksum accumulator.
// TESTING  (CLK_FREQ=1000, BAUD=100 -> BAUD_DIV=10, NUM_CH=4, DATA_W=32)
//  1 Ch2 strobe 32'h8040_1234 -> TX frames A2 80 40 12 34 CSUM=A2^80^40^12^34=44; bits 10 clk each.
//  2 Strobes ch0,1,3 same cycle -> frames in order ch0,ch1,ch3; then ch0 again -> served after ch3.
//  3 CHANGE_ONLY=1: ch1 sends 32'hDEAD_BEEF twice -> one frame; third strobe 32'h0 -> second frame.
//  4 Ch0 strobed 3x while ch3 frame busy -> overrun[0]=1, one ch0 frame with newest data;
//    overrun_clr -> overrun=0.
//  5 rst_n low mid DATA byte -> TX=1, busy=0 next edge; after release no leftover frame emitted.
//  6 ch_enable[2]=0 with strobe -> no frame; pending ch2 re-enabled -> frame sent.

Source files
------------

// File: rtl/joybus_pkg.sv
// Shared constants, FSM state type and baud divisor helper for the JOYBUS->UART bridge.
// No logic, no latency, no flow control.
package joybus_pkg;

  localparam logic [7:0] FRAME_HDR_BASE = 8'hA0;

  typedef enum logic [2:0] {IDLE, LOAD, HDR, DATA, CSUM} state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer: start bit drives TX one clk after accept, each bit BAUD_DIV clks.
// Backpressure: tx_ready low from accept until the clk after the stop bit's last clk.
module uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       TX
);

  localparam int CW = $clog2(BAUD_DIV);

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  assign tx_ready = ~active;

  // bit_cnt counts bits already on the line; bit 9 is the stop bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      TX       <= 1'b1;
    end else if (!active) begin
      if (tx_start) begin
        active   <= 1'b1;
        TX       <= 1'b0;
        shreg    <= {1'b1, tx_byte};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == CW'(BAUD_DIV - 1)) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        active <= 1'b0;
        TX     <= 1'b1;
      end else begin
        TX      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/joybus_uart_bridge.sv
// Captures NUM_CH controller samples, round-robin picks one, frames it (hdr, data MSB first, xor) onto UART.
// Strobe->start bit 4 clks on an idle bridge; no input backpressure, unsent samples overwritten and flagged.
module joybus_uart_bridge
  import joybus_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 32,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int CHANGE_ONLY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] cntlr_data,
  input  logic [NUM_CH-1:0]        cntlr_data_rdy,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     overrun_clr,
  output logic [NUM_CH-1:0]        overrun,
  output logic                     busy,
  output logic                     TX
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int NBYTES   = DATA_W / 8;
  localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BCW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t state, state_nxt;

  logic [DATA_W-1:0] hold      [NUM_CH];
  logic [DATA_W-1:0] last_sent [NUM_CH];
  logic [NUM_CH-1:0] pending, eligible, accept;
  logic [CHW-1:0]    rr_ptr, ch, winner;
  logic              found;
  int                rr_idx;
  logic [DATA_W-1:0] snap;
  logic [BCW-1:0]    byte_cnt;
  logic [7:0]        csum, hdr_byte, tx_byte;
  logic              tx_start, tx_ready;

  assign eligible = pending & ch_enable;
  assign busy     = (state != IDLE);
  assign hdr_byte = FRAME_HDR_BASE | 8'(ch);

  always_comb begin
    accept = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      accept[c] = cntlr_data_rdy[c] & ch_enable[c] &
                  !((CHANGE_ONLY != 0) && (cntlr_data[c*DATA_W +: DATA_W] == last_sent[c]));
    end
  end

  // first eligible channel at or after rr_ptr, wrapping
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    rr_idx = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = int'(rr_ptr) + i;
      if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
      if (!found && eligible[rr_idx]) begin
        found  = 1'b1;
        winner = CHW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_byte   = '0;
    case (state)
      IDLE: if (found) state_nxt = LOAD;
      LOAD: state_nxt = HDR;
      HDR: begin
        tx_start = 1'b1;
        tx_byte  = hdr_byte;
        if (tx_ready) state_nxt = DATA;
      end
      DATA: begin
        tx_start = 1'b1;
        tx_byte  = snap[DATA_W-1 -: 8];
        if (tx_ready && byte_cnt == BCW'(NBYTES - 1)) state_nxt = CSUM;
      end
      CSUM: begin
        tx_start = 1'b1;
        tx_byte  = csum;
        if (tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A strobe landing on the LOAD cycle of its own channel keeps pending set and is not an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      ch       <= '0;
      snap     <= '0;
      byte_cnt <= '0;
      csum     <= '0;
      pending  <= '0;
      overrun  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        hold[c]      <= '0;
        last_sent[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) begin
          hold[c]    <= cntlr_data[c*DATA_W +: DATA_W];
          pending[c] <= 1'b1;
        end else if (state == LOAD && ch == CHW'(c)) begin
          pending[c] <= 1'b0;
        end
        overrun[c] <= (overrun[c] & ~overrun_clr) |
                      (accept[c] & pending[c] & !(state == LOAD && ch == CHW'(c)));
      end
      case (state)
        IDLE: if (found) ch <= winner;
        LOAD: begin
          snap          <= hold[ch];
          last_sent[ch] <= hold[ch];
          rr_ptr        <= (ch == CHW'(NUM_CH - 1)) ? '0 : ch + CHW'(1);
          csum          <= hdr_byte;
          byte_cnt      <= '0;
        end
        DATA: if (tx_ready) begin
          snap     <= snap << 8;
          csum     <= csum ^ snap[DATA_W-1 -: 8];
          byte_cnt <= byte_cnt + BCW'(1);
        end
        default: ;
      endcase
    end
  end

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_ready (tx_ready),
    .TX       (TX)
  );

endmodule

// File: tb/tb_joybus_uart_bridge.sv
// Bench: frame-level model (pending/hold/last_sent, round-robin pick at frame start) plus a bit-exact UART decoder.
module tb_joybus_uart_bridge;

  localparam int BAUD_DIV = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] cntlr_data = '0;
  logic [3:0]   cntlr_data_rdy = '0;
  logic [3:0]   ch_enable = 4'hF;
  logic         overrun_clr = 1'b0;
  logic [3:0]   overrun;
  logic         busy;
  logic         tx;

  always #5 clk = ~clk;

  joybus_uart_bridge #(
    .NUM_CH(4), .DATA_W(32), .CLK_FREQ(1000), .BAUD(100), .CHANGE_ONLY(1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cntlr_data     (cntlr_data),
    .cntlr_data_rdy (cntlr_data_rdy),
    .ch_enable      (ch_enable),
    .overrun_clr    (overrun_clr),
    .overrun        (overrun),
    .busy           (busy),
    .TX             (tx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // behavioural model state
  logic [31:0] m_hold [4];
  logic [31:0] m_last [4];
  logic [3:0]  m_pend = '0;
  logic [3:0]  m_ovr  = '0;
  int          m_rr   = 0;
  int          ch_log[$];
  int          n_frames = 0;
  logic [7:0]  last_bytes [6];
  bit          rx_active = 1'b0;

  function automatic bit m_elig();
    return |(m_pend & ch_enable);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_hold[c] = '0;
      m_last[c] = '0;
    end
    m_pend = '0;
    m_ovr  = '0;
    m_rr   = 0;
  endtask

  function automatic logic [31:0] last_data();
    return {last_bytes[1], last_bytes[2], last_bytes[3], last_bytes[4]};
  endfunction

  task automatic strobe(input logic [3:0] mask, input logic [127:0] data);
    cntlr_data     = data;
    cntlr_data_rdy = mask;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      if (mask[c] && ch_enable[c] && data[c*32 +: 32] !== m_last[c]) begin
        if (m_pend[c]) m_ovr[c] = 1'b1;
        m_hold[c] = data[c*32 +: 32];
        m_pend[c] = 1'b1;
      end
    end
    cntlr_data_rdy = '0;
  endtask

  task automatic pulse_clr();
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    m_ovr = '0;
    overrun_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ch_log.delete();
  endtask

  task automatic wait_quiet(input string name);
    int q;
    q = 0;
    for (int n = 0; n < 3000 && q < 20; n++) begin
      @(negedge clk);
      if (!rx_active && !m_elig() && tx === 1'b1 && busy === 1'b0) q++;
      else q = 0;
    end
    chk(name, 64'(q >= 20), 64'd1);
  endtask

  // one byte, first sample is the current negedge (start bit already seen)
  task automatic rx_byte(output logic [7:0] b, output bit aborted);
    logic [9:0] bits;
    bit bad;
    aborted = 1'b0;
    bad = 1'b0;
    bits = '0;
    b = '0;
    for (int bi = 0; bi < 10; bi++) begin
      for (int j = 0; j < BAUD_DIV; j++) begin
        if (bi != 0 || j != 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          return;
        end
        if (j == 0) bits[bi] = tx;
        else if (tx !== bits[bi]) bad = 1'b1;
      end
    end
    chk("bit_width_stable", 64'(bad), 64'd0);
    chk("start_stop_bits", 64'({bits[0], bits[9]}), 64'b01);
    b = bits[8:1];
  endtask

  always begin : rx_proc
    logic [7:0] exp_b [6];
    logic [7:0] b;
    bit ab;
    int w;
    int idx;
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      rx_active = 1'b1;
      w = -1;
      for (int i = 0; i < 4; i++) begin
        idx = (m_rr + i) % 4;
        if (w < 0 && m_pend[idx] && ch_enable[idx]) w = idx;
      end
      chk("frame_start_eligible", 64'(w >= 0), 64'd1);
      if (w >= 0) begin
        exp_b[0] = 8'hA0 | 8'(w);
        exp_b[5] = exp_b[0];
        for (int j = 0; j < 4; j++) begin
          exp_b[1+j] = m_hold[w][31-8*j -: 8];
          exp_b[5] = exp_b[5] ^ exp_b[1+j];
        end
        m_pend[w] = 1'b0;
        m_last[w] = m_hold[w];
        m_rr = (w + 1) % 4;
        ch_log.push_back(w);
        n_frames++;
      end
      ab = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) begin
          @(negedge clk);
          if (rst_n !== 1'b1) break;
          chk("byte_gap_idle", 64'(tx), 64'd1);
          @(negedge clk);
          if (rst_n !== 1'b1) break;
          chk("byte_gap_start", 64'(tx), 64'd0);
        end
        rx_byte(b, ab);
        if (ab) break;
        last_bytes[k] = b;
        if (w >= 0) chk($sformatf("frame_byte%0d", k), 64'(b), 64'(exp_b[k]));
      end
      rx_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("overrun_vs_model", 64'(overrun), 64'(m_ovr));
      if (!rx_active && !m_elig()) chk("busy_when_idle", 64'(busy), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nb, hi, f0;
    logic b1, b2;
    logic [15:0] ord;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single frame, latency and literal bytes
    strobe(4'b0100, {32'h0, 32'h8040_1234, 64'h0});
    hi = 0; b1 = 1'bx; b2 = 1'bx;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) b1 = busy;
      if (n == 1) b2 = busy;
      if (tx === 1'b0) break;
      hi++;
    end
    chk("t1_latency_to_start", 64'(hi), 64'd3);
    chk("t1_busy_t1_t2", 64'({b1, b2}), 64'b01);
    wait_quiet("t1_quiet");
    chk("t1_bytes", {16'h0, last_bytes[0], last_bytes[1], last_bytes[2], last_bytes[3],
                     last_bytes[4], last_bytes[5]}, 64'hA2_80_40_12_34_44);
    chk("t1_frames", 64'(ch_log.size()), 64'd1);

    // 2: simultaneous strobes, then ch0 again during ch1's frame
    do_reset();
    strobe(4'b1011, {32'h0303_0D0D, 32'h0, 32'h0101_0B0B, 32'h0000_0A0A});
    for (int n = 0; n < 3000 && ch_log.size() < 2; n++) @(negedge clk);
    chk("t2_reach_ch1", 64'(ch_log.size() >= 2), 64'd1);
    repeat (30) @(negedge clk);
    strobe(4'b0001, {96'h0, 32'h0000_0E0E});
    wait_quiet("t2_quiet");
    ord = '0;
    foreach (ch_log[i]) ord = {ord[11:0], 4'(ch_log[i])};
    chk("t2_order", 64'(ord), 64'h0130);
    chk("t2_last_ch0_data", 64'(last_data()), 64'h0000_0E0E);

    // 3: change-only filter
    do_reset();
    f0 = n_frames;
    strobe(4'b0010, {64'h0, 32'hDEAD_BEEF, 32'h0});
    wait_quiet("t3_quiet_a");
    strobe(4'b0010, {64'h0, 32'hDEAD_BEEF, 32'h0});
    wait_quiet("t3_quiet_b");
    chk("t3_dup_dropped", 64'(n_frames - f0), 64'd1);
    strobe(4'b0010, 128'h0);
    wait_quiet("t3_quiet_c");
    chk("t3_zero_sent", 64'(n_frames - f0), 64'd2);
    chk("t3_zero_data", 64'(last_data()), 64'h0);
    chk("t3_zero_csum", 64'(last_bytes[5]), 64'hA1);

    // 4: overrun while another channel transmits
    do_reset();
    strobe(4'b1000, {32'h0303_0303, 96'h0});
    repeat (30) @(negedge clk);
    strobe(4'b0001, {96'h0, 32'h1111_1111});
    strobe(4'b0001, {96'h0, 32'h2222_2222});
    strobe(4'b0001, {96'h0, 32'hC0DE_0042});
    chk("t4_overrun_set", 64'(overrun), 64'h1);
    wait_quiet("t4_quiet");
    chk("t4_overrun_sticky", 64'(overrun), 64'h1);
    nb = ch_log.size();
    chk("t4_frames", 64'(nb), 64'd2);
    if (nb == 2) chk("t4_order", 64'({4'(ch_log[0]), 4'(ch_log[1])}), 64'h30);
    chk("t4_newest_data", 64'(last_data()), 64'hC0DE_0042);
    pulse_clr();
    @(negedge clk);
    chk("t4_overrun_cleared", 64'(overrun), 64'h0);

    // 5: reset in the middle of a data byte
    do_reset();
    strobe(4'b0100, {32'h5555_AAAA, 64'h0});
    repeat (160) @(negedge clk);
    f0 = n_frames;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_reset_tx", 64'(tx), 64'd1);
    chk("t5_reset_busy", 64'(busy), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    wait_quiet("t5_quiet");
    chk("t5_no_leftover", 64'(n_frames - f0), 64'd0);

    // 6: pending channel masked by ch_enable, then released
    do_reset();
    strobe(4'b0010, {64'h0, 32'h1111_0001, 32'h0});
    repeat (30) @(negedge clk);
    strobe(4'b0100, {32'h2222_0002, 64'h0});
    @(posedge clk); #1;
    ch_enable = 4'b1011;
    strobe(4'b0100, {32'h9999_9999, 64'h0});
    wait_quiet("t6_quiet_masked");
    repeat (50) @(negedge clk);
    chk("t6_masked_frames", 64'(ch_log.size()), 64'd1);
    @(posedge clk); #1;
    ch_enable = 4'hF;
    wait_quiet("t6_quiet_released");
    nb = ch_log.size();
    chk("t6_frames", 64'(nb), 64'd2);
    if (nb == 2) chk("t6_second_ch", 64'(ch_log[1]), 64'd2);
    chk("t6_held_data", 64'(last_data()), 64'h2222_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
